spi_slave_regs: RTL and testbench

SPI slave endpoint that receives the 24-bit command/address/payload frames produced by `spi_master_mock` and maintains a small 8-bit register file. Write frames update a register. Read frames shift the addressed register back on `miso`. Register 0 drives the LED brightness value consumed downstream. All logic runs in the `sysclk` domain: `cs`, `sclk` and `mosi` are oversampled, not used as clocks.

---
 rtl/spi_slave_regs.sv | 170 +++++++++++++++++
 tb/tb_spi_slave_regs.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regs.sv
// SPI slave endpoint with a small 8-bit register file; CS/SCLK/MOSI are
// oversampled in the sysclk domain. Register 0 drives the LED brightness.
module spi_slave_regs #(
    parameter int NUM_REGS         = 4,
    parameter int BRIGHTNESS_WIDTH = 7
) (
    input  logic                        sysclk,
    input  logic                        rst_n,
    input  logic                        cs,
    input  logic                        sclk,
    input  logic                        mosi,
    output logic                        miso,
    output logic [BRIGHTNESS_WIDTH-1:0] o_brightness,
    output logic                        o_wr_strobe,
    output logic                        o_frame_err,
    output logic [7:0]                  o_frame_cnt
);

    localparam int CMD_BITS           = 8;
    localparam int ADDR_BITS          = 8;
    localparam int PAYLOAD_BITS       = 8;
    localparam int MASTER_FRAME_WIDTH = 24;
    localparam logic CS_DEASSERT      = 1'b1;
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [CMD_BITS-1:0] CMD_WRITE = 8'h80;
    localparam logic [CMD_BITS-1:0] CMD_READ  = 8'h40;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CMD  = 3'd1;
    localparam logic [2:0] ADDR = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0] cs_p;
    logic [2:0] sclk_p;
    logic [1:0] mosi_p;

    logic [2:0]                    state;
    logic [4:0]                    cnt;
    logic [MASTER_FRAME_WIDTH-2:0] shreg;
    logic [MASTER_FRAME_WIDTH-1:0] frame;
    logic [7:0]                    tx;
    logic                          tx_en;
    logic [7:0]                    regs [NUM_REGS];

    logic                 cs_idle;
    logic                 cs_fall;
    logic                 cs_rise;
    logic                 sclk_rise;
    logic                 sclk_fall;
    logic [CMD_BITS-1:0]  cmd_early;
    logic [CMD_BITS-1:0]  cmd_full;
    logic [ADDR_BITS-1:0] addr_early;
    logic [ADDR_BITS-1:0] addr_full;
    logic                 rd_hit;
    logic                 wr_hit;

    // The bit being sampled this cycle completes the frame view.
    assign frame      = {shreg, mosi_p[1]};
    assign cs_idle    = (cs_p[1] == CS_DEASSERT);
    assign cs_fall    = (cs_p[2] == CS_DEASSERT) && !cs_idle;
    assign cs_rise    = (cs_p[2] != CS_DEASSERT) && cs_idle;
    assign sclk_rise  = sclk_p[1] & ~sclk_p[2];
    assign sclk_fall  = ~sclk_p[1] & sclk_p[2];
    assign cmd_early  = frame[ADDR_BITS +: CMD_BITS];
    assign addr_early = frame[ADDR_BITS-1:0];
    assign cmd_full   = frame[MASTER_FRAME_WIDTH-1 -: CMD_BITS];
    assign addr_full  = frame[PAYLOAD_BITS +: ADDR_BITS];
    assign rd_hit     = (cmd_early == CMD_READ) && (int'(addr_early) < NUM_REGS);
    assign wr_hit     = int'(addr_full) < NUM_REGS;

    assign miso         = tx_en & tx[7];
    assign o_brightness = regs[0][BRIGHTNESS_WIDTH-1:0];

    // CS resets to "asserted" so a CS already low at release never looks
    // like a falling edge; a real frame needs CS to go high first.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cs_p   <= {3{~CS_DEASSERT}};
            sclk_p <= '0;
            mosi_p <= '0;
        end else begin
            cs_p   <= {cs_p[1:0], cs};
            sclk_p <= {sclk_p[1:0], sclk};
            mosi_p <= {mosi_p[0], mosi};
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            tx          <= '0;
            tx_en       <= 1'b0;
            o_wr_strobe <= 1'b0;
            o_frame_err <= 1'b0;
            o_frame_cnt <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            o_wr_strobe <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    shreg <= '0;
                    tx    <= '0;
                    tx_en <= 1'b0;
                    if (cs_fall) begin
                        state <= CMD;
                        if (sclk_rise) begin
                            shreg <= {{(MASTER_FRAME_WIDTH-2){1'b0}}, mosi_p[1]};
                            cnt   <= 5'd1;
                        end
                    end
                end
                CMD, ADDR, DATA: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        tx_en       <= 1'b0;
                        o_frame_err <= 1'b1;
                    end else if (sclk_rise) begin
                        shreg <= frame[MASTER_FRAME_WIDTH-2:0];
                        cnt   <= cnt + 5'd1;
                        if (state == CMD && cnt == 5'd7) begin
                            state <= ADDR;
                        end
                        if (state == ADDR && cnt == 5'd15) begin
                            state <= DATA;
                            tx    <= rd_hit ? regs[addr_early[AW-1:0]] : '0;
                        end
                        if (state == DATA && cnt == 5'd23) begin
                            state <= DONE;
                            tx_en <= 1'b0;
                            case (cmd_full)
                                CMD_WRITE: begin
                                    if (wr_hit) begin
                                        regs[addr_full[AW-1:0]] <=
                                            frame[PAYLOAD_BITS-1:0];
                                        o_wr_strobe <= 1'b1;
                                    end
                                    o_frame_cnt <= o_frame_cnt + 8'd1;
                                end
                                CMD_READ: o_frame_cnt <= o_frame_cnt + 8'd1;
                                default:  o_frame_err <= 1'b1;
                            endcase
                        end
                    end else if (sclk_fall && state == DATA) begin
                        // First falling edge exposes the MSB, later ones shift.
                        if (tx_en) begin
                            tx <= {tx[6:0], 1'b0};
                        end else begin
                            tx_en <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (cs_idle) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed SPI frames for spi_slave_regs, checked against a frame-level
// register model plus literal expectations.
module tb_spi_slave_regs;

    localparam int H = 4;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       cs;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [6:0] o_brightness;
    logic       o_wr_strobe;
    logic       o_frame_err;
    logic [7:0] o_frame_cnt;

    int   passed = 0;
    int   total = 0;
    int   strobe_seen = 0;
    int   err_seen = 0;
    bit   settled = 1'b0;
    logic [7:0] m_regs [4];
    int   m_cnt = 0;

    always #4 sysclk = ~sysclk;

    spi_slave_regs dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .cs           (cs),
        .sclk         (sclk),
        .mosi         (mosi),
        .miso         (miso),
        .o_brightness (o_brightness),
        .o_wr_strobe  (o_wr_strobe),
        .o_frame_err  (o_frame_err),
        .o_frame_cnt  (o_frame_cnt)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic shift_bits(input logic [23:0] f, input int nbits,
                              output logic [7:0] rx, output int early);
        rx = '0;
        early = 0;
        for (int i = 0; i < nbits; i++) begin
            mosi = f[23-i];
            tick(H);
            sclk = 1'b1;
            if (i >= 16) rx = {rx[6:0], miso};
            else if (miso !== 1'b0) early++;
            tick(H);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [23:0] f, input int nbits,
                             output logic [7:0] rx);
        int s0, e0, early, e_str, e_err;
        logic [7:0] e_rd;
        settled = 1'b0;
        s0 = strobe_seen;
        e0 = err_seen;
        cs = 1'b0;
        tick(2);
        shift_bits(f, nbits, rx, early);
        tick(2);
        cs = 1'b1;
        tick(8);
        e_rd = '0;
        e_str = 0;
        e_err = 0;
        if (nbits < 24) begin
            e_err = 1;
        end else if (f[23:16] == 8'h80) begin
            if (f[15:8] < 8'd4) begin
                m_regs[f[9:8]] = f[7:0];
                e_str = 1;
            end
            m_cnt = (m_cnt + 1) % 256;
        end else if (f[23:16] == 8'h40) begin
            if (f[15:8] < 8'd4) e_rd = m_regs[f[9:8]];
            m_cnt = (m_cnt + 1) % 256;
        end else begin
            e_err = 1;
        end
        check("rd_data", rx, e_rd);
        check("miso_cmd_addr", early, 0);
        check("wr_strobe_pulses", strobe_seen - s0, e_str);
        check("frame_err_pulses", err_seen - e0, e_err);
        settled = 1'b1;
    endtask

    always @(negedge sysclk) begin
        if (rst_n) begin
            if (o_wr_strobe) strobe_seen <= strobe_seen + 1;
            if (o_frame_err) err_seen <= err_seen + 1;
            if (settled) begin
                check("brightness", o_brightness, m_regs[0][6:0]);
                check("frame_cnt", o_frame_cnt, m_cnt);
                check("miso_idle", miso, 0);
            end
        end
    end

    initial begin
        logic [7:0] rx;
        int s0, e0, early;
        rst_n = 1'b0;
        cs = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        tick(3);
        check("rst_miso", miso, 0);
        check("rst_brightness", o_brightness, 0);
        check("rst_wr_strobe", o_wr_strobe, 0);
        check("rst_frame_err", o_frame_err, 0);
        check("rst_frame_cnt", o_frame_cnt, 0);
        rst_n = 1'b1;
        tick(4);
        settled = 1'b1;

        run_frame(24'h8000D1, 24, rx);
        check("lit_brightness_51", o_brightness, 7'h51);
        check("lit_cnt_1", o_frame_cnt, 1);
        run_frame(24'h400098, 24, rx);
        check("lit_read_d1", rx, 8'hD1);
        check("lit_cnt_2", o_frame_cnt, 2);
        run_frame(24'h80A0FF, 24, rx);
        check("lit_cnt_3", o_frame_cnt, 3);
        e0 = err_seen;
        run_frame(24'h800155, 12, rx);
        check("lit_abort_err", err_seen - e0, 1);
        check("lit_cnt_abort", o_frame_cnt, 3);
        run_frame(24'h400100, 24, rx);
        check("lit_reg1_untouched", rx, 8'h00);
        run_frame(24'h800155, 24, rx);
        run_frame(24'h400100, 24, rx);
        check("lit_reg1_55", rx, 8'h55);
        check("lit_cnt_6", o_frame_cnt, 6);

        for (int i = 0; i < 250; i++) begin
            run_frame({8'h80, 8'h02, 8'(i)}, 24, rx);
        end
        check("lit_cnt_wrap", o_frame_cnt, 0);
        run_frame(24'h400200, 24, rx);
        check("lit_reg2_f9", rx, 8'hF9);

        e0 = err_seen;
        run_frame(24'h3C0012, 24, rx);
        check("lit_unknown_err", err_seen - e0, 1);
        check("lit_unknown_cnt", o_frame_cnt, 1);
        run_frame(24'h400000, 24, rx);
        check("lit_reg0_kept", rx, 8'hD1);
        run_frame(24'h8003AA, 24, rx);
        run_frame(24'h400300, 24, rx);
        check("lit_reg3_aa", rx, 8'hAA);

        settled = 1'b0;
        cs = 1'b0;
        tick(2);
        shift_bits(24'h80027F, 20, rx, early);
        rst_n = 1'b0;
        tick(1);
        check("midrst_frame_cnt", o_frame_cnt, 0);
        check("midrst_brightness", o_brightness, 0);
        check("midrst_miso", miso, 0);
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_cnt = 0;
        s0 = strobe_seen;
        e0 = err_seen;
        tick(4);
        shift_bits(24'h800033, 24, rx, early);
        tick(2);
        cs = 1'b1;
        tick(8);
        check("ghost_strobe", strobe_seen - s0, 0);
        check("ghost_err", err_seen - e0, 0);
        check("ghost_cnt", o_frame_cnt, 0);
        settled = 1'b1;
        run_frame(24'h400300, 24, rx);
        check("lit_reg3_cleared", rx, 8'h00);
        run_frame(24'h400000, 24, rx);
        check("lit_reg0_cleared", rx, 8'h00);
        check("lit_cnt_after_rst", o_frame_cnt, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
